pipe_loader: RTL
================

# pipe_loader

- Program/data loader for the 5-stage RISC-V pipeline.
- Direction: the write side of the path the pipeline testbench reads. The testbench dumps instruction, register-file and data-memory contents; this block writes instruction and data memory from a host byte stream, then releases the core from reset.
- Position: between a host byte source (UART receiver or bench driver) and the core's memory write ports. Its `core_reset` output drives the core's active-high `reset`.

## Interface
Parameters:
- `IMEM_AW`, 8: instruction-memory word-address width; 32-bit words.
- `DMEM_AW`, 8: data-memory word-address width; 64-bit words.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  `IMEM_AW`  instruction word index.
- `imem_wdata`  out  32  instruction word.
- `dmem_we`  out  1  data-memory write strobe.
- `dmem_addr`  out  `DMEM_AW`  data word index.
- `dmem_wdata`  out  64  data word.
- `core_reset`  out  1  active-high reset to the pipeline.
- `busy`  out  1  a load command is in progress.
- `err`  out  1  sticky error.
- `ovf`  out  1  sticky address wrap.

## Operation
- A byte transfers when `in_valid && in_ready` at a rising edge.
- Command bytes (accepted in IDLE):
  - 0x01: load IMEM.
  - 0x02: load DMEM.
  - 0x03: run.
  - Any other byte: dropped, `err` set, state stays IDLE.
- Load command sequence: command byte, then count_lo, then count_hi (16-bit word count N), then N words.
  - Each word is little-endian: 4 bytes for IMEM, 8 bytes for DMEM.
- FSM states:
  - IDLE → CNT_LO (on 0x01/0x02) or RUN (on 0x03).
  - CNT_LO → CNT_HI.
  - CNT_HI → IDLE if N==0, else DATA.
  - DATA → WRITE after the last byte of a word.
  - WRITE → DATA, or → IDLE after word N. With LOADER_CHECKSUM_EN defined, → CHK instead of IDLE.
  - CHK → IDLE.
  - RUN: only byte 0xFF acts; it returns to IDLE and reasserts `core_reset`. All other bytes are consumed and ignored.
- Word address starts at 0 on every load command and increments after each write.
  - Wrap from 2^AW−1 to 0 sets `ovf`. The write still occurs.
- `busy` is 1 in CNT_LO, CNT_HI, DATA, WRITE and CHK.
- `core_reset` is 1 in every state except RUN.
- Write data and address are held stable from the WRITE cycle until the next write.
- `err` and `ovf` clear only on `reset`.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `in_ready`=0, `core_reset`=1.
  - `imem_we`=`dmem_we`=0.
  - `imem_addr`=`dmem_addr`=0, `imem_wdata`=`dmem_wdata`=0.
  - `busy`=`err`=`ovf`=0.
  - State = IDLE.
- `in_ready`=1 in every state except WRITE.
- The cycle after the last byte of a word is accepted, the FSM is in WRITE and the strobe is high for exactly that cycle.
- Throughput:
  - IMEM: one word per 5 cycles.
  - DMEM: one word per 9 cycles.
- `core_reset` falls in the cycle after 0x03 is accepted. It rises in the cycle after 0xFF is accepted in RUN.
- Reset mid-load: the partial word is discarded and no strobe is issued. The memory contents already written are left unchanged.
- `in_valid` low in the middle of a word: the FSM holds its state and partial word indefinitely. There is no timeout.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined:
  - Every load command is followed by one checksum byte, accepted in CHK.
  - Checksum = XOR of all data bytes of the command (count bytes excluded).
  - Mismatch sets `err`. Words already written are kept.
- Undefined:
  - No CHK state. WRITE of the last word → IDLE.
  - `err` is set only by unknown commands.

## Test plan
- IMEM load: reset, send 01 02 00 13 00 50 00 93 00 A0 00. Required:
  - `imem_we` pulses twice: addr 0 data 0x00500013, then addr 1 data 0x00A00093.
  - `busy` returns to 0.
  - `core_reset` stays 1.
- DMEM load: send 02 01 00 EF CD AB 89 67 45 23 01. Required: one `dmem_we` pulse, addr 0, data 0x0123456789ABCDEF.
- Run/halt:
  - Send 03: `core_reset`=0 from the next cycle. Bytes 0x01 and 0x22 are ignored.
  - Send FF: `core_reset`=1 the next cycle, state IDLE.
- Errors and empty load:
  - Send 0x7E in IDLE: `err`=1, no strobes.
  - Send 01 00 00: no strobe, back in IDLE, `busy`=0.
- Wrap and mid-load reset:
  - With `IMEM_AW`=2, load 5 IMEM words: the 5th word is written to addr 0 and `ovf`=1.
  - Assert `reset` after 2 bytes of a word: no strobe, all outputs at their reset values.
- Checksum (`LOADER_CHECKSUM_EN` defined):
  - Send 01 01 00 13 00 50 00 43 (0x13^0x00^0x50^0x00 = 0x43): word written, `err`=0.
  - Repeat with checksum 0x44: word written, `err`=1.

Source files
------------

// File: rtl/pipe_loader_if.sv
// pipe_loader_if: host byte stream and memory write ports of the program loader.
// master = host/bench side (drives the byte stream), slave = loader side.
interface pipe_loader_if #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [63:0]        dmem_wdata;
    logic               core_reset;
    logic               busy;
    logic               err;
    logic               ovf;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, core_reset, busy, err, ovf
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, core_reset, busy, err, ovf
    );
endinterface

// File: rtl/pipe_loader.sv
// pipe_loader: writes instruction/data memory from a host byte stream, then
// releases the 5-stage core from reset.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after each load).
module pipe_loader #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    pipe_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_RUN
`ifdef LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;
    logic               r_is_dmem;
    logic [7:0]         r_cnt_lo;
    logic [15:0]        r_remain;
    logic [2:0]         r_byte_idx;
    logic [63:0]        r_word;
    logic [IMEM_AW-1:0] r_inext;
    logic [DMEM_AW-1:0] r_dnext;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic [63:0]        r_dmem_wdata;
    logic               r_err;
    logic               r_ovf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_fire;
    logic               w_last_byte;
    logic               w_busy;
    logic               w_core_reset;
    logic               w_imem_we;
    logic               w_dmem_we;
    logic [63:0]        w_asm;

    assign w_fire      = bus.in_valid && r_in_ready;
    assign w_last_byte = (r_byte_idx == (r_is_dmem ? 3'd7 : 3'd3));

    // Current word with the incoming byte merged into its little-endian slot.
    always_comb begin
        w_asm = r_word;
        w_asm[{r_byte_idx, 3'b000} +: 8] = bus.in_data;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next       = r_state;
        w_busy       = 1'b0;
        w_core_reset = 1'b1;
        w_imem_we    = 1'b0;
        w_dmem_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    case (bus.in_data)
                        8'h01, 8'h02: w_next = S_CNT_LO;
                        8'h03:        w_next = S_RUN;
                        default:      w_next = S_IDLE;
                    endcase
                end
            end
            S_CNT_LO: begin
                w_busy = 1'b1;
                if (w_fire) w_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                w_busy = 1'b1;
                if (w_fire) w_next = ({bus.in_data, r_cnt_lo} == 16'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                w_busy = 1'b1;
                if (w_fire && w_last_byte) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_busy    = 1'b1;
                w_imem_we = !r_is_dmem;
                w_dmem_we = r_is_dmem;
`ifdef LOADER_CHECKSUM_EN
                w_next = (r_remain == 16'd0) ? S_CHK : S_DATA;
`else
                w_next = (r_remain == 16'd0) ? S_IDLE : S_DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                w_busy = 1'b1;
                if (w_fire) w_next = S_IDLE;
            end
`endif
            S_RUN: begin
                w_core_reset = 1'b0;
                if (w_fire && bus.in_data == 8'hFF) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Byte assembly, address counters, write-port registers and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready   <= 1'b0;
            r_is_dmem    <= 1'b0;
            r_cnt_lo     <= '0;
            r_remain     <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_inext      <= '0;
            r_dnext      <= '0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_err        <= 1'b0;
            r_ovf        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_in_ready <= (w_next != S_WRITE);
            if (w_fire) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.in_data == 8'h01 || bus.in_data == 8'h02) begin
                            r_is_dmem  <= bus.in_data[1];
                            r_byte_idx <= '0;
                            r_inext    <= '0;
                            r_dnext    <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                        end else if (bus.in_data != 8'h03) begin
                            r_err <= 1'b1;
                        end
                    end
                    S_CNT_LO: r_cnt_lo <= bus.in_data;
                    S_CNT_HI: r_remain <= {bus.in_data, r_cnt_lo};
                    S_DATA: begin
                        r_word <= w_asm;
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.in_data;
`endif
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            r_remain   <= r_remain - 16'd1;
                            if (r_is_dmem) begin
                                r_dmem_addr  <= r_dnext;
                                r_dmem_wdata <= w_asm;
                                r_dnext      <= r_dnext + 1'b1;
                                if (&r_dnext) r_ovf <= 1'b1;
                            end else begin
                                r_imem_addr  <= r_inext;
                                r_imem_wdata <= w_asm[31:0];
                                r_inext      <= r_inext + 1'b1;
                                if (&r_inext) r_ovf <= 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: if (bus.in_data != r_csum) r_err <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = w_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.core_reset = w_core_reset;
    assign bus.busy       = w_busy;
    assign bus.err        = r_err;
    assign bus.ovf        = r_ovf;

endmodule
